mult_accum: RTL and testbench

MULT_ACCUM -- requirements
Module: mult_accum

---
 rtl/mult_accum.sv | 62 ++++++
 tb/tb_mult_accum.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mult_accum.sv
// mult_accum: accumulates a run of small unsigned products with wrap-around and a sticky overflow flag
module mult_accum #(
    parameter int ACC_W = 6,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [3:0]       P,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, state_nxt;
    logic [LEN_W:0] cnt;
    logic [ACC_W:0] sum;
    logic xfer;
    assign in_ready = state == ACCUM && !clr;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign xfer     = in_valid && in_ready;
    assign sum      = {1'b0, acc} + (ACC_W + 1)'(P);
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    // next state: clr wins, DONE lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        if (clr) state_nxt = IDLE;
        else if (state == IDLE && start) state_nxt = ACCUM;
        else if (xfer && cnt == (LEN_W + 1)'(1)) state_nxt = DONE;
        else if (state == DONE) state_nxt = IDLE;
    end
    // datapath: count is one bit wider so len=0 can load 2**LEN_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if (state == IDLE && start) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= len == '0 ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
        end else if (xfer) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | sum[ACC_W];
            cnt <= cnt - (LEN_W + 1)'(1);
        end
    end
endmodule

// File: tb/tb_mult_accum.sv
// tb_mult_accum: randomized scoreboard bench for mult_accum
module tb_mult_accum;
    localparam int ACC_W = 6;
    localparam int LEN_W = 4;
    localparam int MOD = 2 ** ACC_W;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [3:0] P = '0;
    logic in_ready, busy, done, ovf;
    logic [ACC_W-1:0] acc;
    logic pend = 1'b0;
    int errors = 0;
    int checks = 0;
    int step_q[$];
    int fin_q[$];

    mult_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .clr(clr),
        .in_valid(in_valid), .P(P), .in_ready(in_ready), .acc(acc),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected {acc, ovf} from the unwrapped running total
    function automatic int enc(input int total);
        return ((total % MOD) << 1) | int'(total >= MOD);
    endfunction

    // monitor: checks acc/ovf after every observed transfer and at every done pulse
    always @(negedge clk) begin
        if (pend) begin
            if (step_q.size() == 0) check("extra transfer", 1, 0);
            else check("step acc/ovf", {acc, ovf}, step_q.pop_front());
        end
        if (done) begin
            if (fin_q.size() == 0) check("unexpected done", 1, 0);
            else begin
                check("done acc/ovf", {acc, ovf}, fin_q.pop_front());
                check("done timing", {31'd0, pend && step_q.size() == 0}, 1);
            end
        end
        pend <= in_valid & in_ready & rst_n;
    end

    // vmode: 0 always valid, 1 toggling, 2 random; fixed_p<0 gives random P
    task automatic run(input logic [LEN_W-1:0] l, input int fixed_p, input int vmode,
                       input int clr_at, input int rst_at, input bit noise);
        int n = (l == 0) ? 2 ** LEN_W : int'(l);
        int total = 0;
        int got = 0;
        int cyc = 0;
        start = 1'b1;
        len = l;
        @(posedge clk); #1;
        start = 1'b0;
        len = LEN_W'($urandom);
        while (got < n) begin
            if (got == rst_at) begin
                in_valid = 1'b0;
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                check("rst acc", {26'd0, acc}, 0);
                check("rst flags", {busy, done, ovf, in_ready}, 0);
                #1;
                rst_n = 1'b1;
                return;
            end
            in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            P = fixed_p < 0 ? 4'($urandom) : 4'(fixed_p);
            start = noise ? 1'($urandom) : 1'b0;
            if (got == clr_at && in_valid) begin
                clr = 1'b1;
                @(posedge clk); #1;
                clr = 1'b0;
                in_valid = 1'b0;
                start = 1'b0;
                check("clr acc/ovf", {acc, ovf}, 0);
                check("clr ready/busy", {in_ready, busy}, 0);
                repeat (2) @(posedge clk);
                #1;
                return;
            end
            if (in_valid) begin
                total += int'(P);
                got++;
                step_q.push_back(enc(total));
            end
            @(posedge clk); #1;
            cyc++;
        end
        fin_q.push_back(enc(total));
        in_valid = 1'b1;
        P = 4'($urandom);
        start = noise;
        @(posedge clk); #1;
        in_valid = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("done seen", fin_q.size(), 0);
        check("idle hold acc/ovf", {acc, ovf}, enc(total));
        check("idle busy", {31'd0, busy}, 0);
    endtask

    initial begin
        #12;
        check("reset acc", {26'd0, acc}, 0);
        check("reset flags", {busy, done, ovf, in_ready}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(4, 9, 0, -1, -1, 1'b0);
        run(8, 9, 0, -1, -1, 1'b0);
        run(0, 1, 0, -1, -1, 1'b0);
        run(3, -1, 1, -1, -1, 1'b1);
        run(5, -1, 0, 2, -1, 1'b0);
        run(5, -1, 0, -1, 3, 1'b0);
        run(2, 3, 0, -1, -1, 1'b0);
        for (int i = 0; i < 25; i++)
            run(LEN_W'($urandom), -1, 2, -1, -1, 1'($urandom));
        repeat (3) @(posedge clk);
        #1;
        check("step queue drained", step_q.size(), 0);
        check("final queue drained", fin_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
